// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and encodings for the pipeline hazard controller.
//   dmiss_state_e   : data-cache miss FSM states (RUN, MISS)
//   RESULT_SRC_LOAD : ResultSrc encoding that marks a load in execute
//   FWD_*           : forwarding select encodings for ForwardA_e/ForwardB_e
package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } dmiss_state_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: combinational forwarding select for one execute operand.
//   rs                       : execute-stage source register
//   rd_m, rd_w               : destination registers in M and W
//   reg_write_m, reg_write_w : write enables in M and W
//   valid_m, valid_w         : stage valid bits in M and W
//   fwd                      : FWD_MEM, FWD_WB or FWD_RF
// M is checked first so the youngest producer wins when both stages match.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  input  logic                      valid_m,
  input  logic                      valid_w,
  output logic [1:0]                fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (valid_m && reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      fwd = FWD_MEM;
    end else if (valid_w && reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control unit. Drives every stage register's enable,
// synchronous flush and valid input, and resolves load-use, redirect,
// data-cache miss and instruction-cache miss hazards.
//   clk, rst_n                     : clock, synchronous active-low reset
//   Rs1_d/Rs2_d, use_rs1_d/use_rs2_d : decode sources and whether they are read
//   Rs1_e/Rs2_e                    : execute sources (forwarding)
//   Rd_*/RegWrite_*/valid_*        : producer info per stage
//   ResultSrc_e                    : execute result source (load detection)
//   redirect_e                     : taken branch/jump resolved in execute
//   dcache_miss, dcache_ready      : D-cache miss level / refill-done pulse
//   icache_miss                    : fetch miss level
//   en_f..en_mw                    : stage enables (0 = hold)
//   flush_n_fd, flush_n_de         : active-low synchronous clears
//   valid_gate_f/d/m               : valid written into F/D, D/E, M/W
//   ForwardA_e, ForwardB_e         : execute operand forwarding selects
//   stall_count                    : saturating count of cycles with en_fd=0
//   dmiss_busy                     : miss FSM is in MISS (FSM state view)
//
// Handshake note: dcache_miss is a level qualified by valid_m; dcache_ready is
// a one-cycle pulse only honoured in MISS. The cycle in which ready is seen is
// still frozen; the pipeline resumes on the following cycle.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REG_ADDR_WIDTH-1:0]  Rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0]  Rs2_d,
  input  logic                       use_rs1_d,
  input  logic                       use_rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0]  Rs1_e,
  input  logic [REG_ADDR_WIDTH-1:0]  Rs2_e,
  input  logic [REG_ADDR_WIDTH-1:0]  Rd_e,
  input  logic [REG_ADDR_WIDTH-1:0]  Rd_m,
  input  logic [REG_ADDR_WIDTH-1:0]  Rd_w,
  input  logic                       RegWrite_e,
  input  logic                       RegWrite_m,
  input  logic                       RegWrite_w,
  input  logic                       valid_e,
  input  logic                       valid_m,
  input  logic                       valid_w,
  input  logic [1:0]                 ResultSrc_e,
  input  logic                       redirect_e,
  input  logic                       dcache_miss,
  input  logic                       dcache_ready,
  input  logic                       icache_miss,
  output logic                       en_f,
  output logic                       en_fd,
  output logic                       en_de,
  output logic                       en_em,
  output logic                       en_mw,
  output logic                       flush_n_fd,
  output logic                       flush_n_de,
  output logic                       valid_gate_f,
  output logic                       valid_gate_d,
  output logic                       valid_gate_m,
  output logic [1:0]                 ForwardA_e,
  output logic [1:0]                 ForwardB_e,
  output logic [STALL_CNT_WIDTH-1:0] stall_count,
  output logic                       dmiss_busy
);

  dmiss_state_e state, state_next;
  logic         freeze;
  logic         load_use;
  logic [1:0]   fwd_a, fwd_b;

  hazard_forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs          (Rs1_e),
    .rd_m        (Rd_m),
    .rd_w        (Rd_w),
    .reg_write_m (RegWrite_m),
    .reg_write_w (RegWrite_w),
    .valid_m     (valid_m),
    .valid_w     (valid_w),
    .fwd         (fwd_a)
  );

  hazard_forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs          (Rs2_e),
    .rd_m        (Rd_m),
    .rd_w        (Rd_w),
    .reg_write_m (RegWrite_m),
    .reg_write_w (RegWrite_w),
    .valid_m     (valid_m),
    .valid_w     (valid_w),
    .fwd         (fwd_b)
  );

  // The entry cycle freezes too, so the missing access is held in M from the
  // very cycle the miss is reported.
  assign freeze = (state == MISS) || (dcache_miss && valid_m);

  assign load_use = (ResultSrc_e == RESULT_SRC_LOAD) && valid_e && RegWrite_e &&
                    (Rd_e != '0) &&
                    ((use_rs1_d && (Rd_e == Rs1_d)) || (use_rs2_d && (Rd_e == Rs2_d)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (dcache_miss && valid_m) state_next = MISS;
      MISS:    if (dcache_ready)           state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    en_f         = 1'b1;
    en_fd        = 1'b1;
    en_de        = 1'b1;
    en_em        = 1'b1;
    en_mw        = 1'b1;
    flush_n_fd   = 1'b1;
    flush_n_de   = 1'b1;
    valid_gate_f = 1'b1;
    valid_gate_d = 1'b1;
    valid_gate_m = 1'b1;
    ForwardA_e   = fwd_a;
    ForwardB_e   = fwd_b;
    dmiss_busy   = (state == MISS);
    if (!rst_n) begin
      flush_n_fd   = 1'b0;
      flush_n_de   = 1'b0;
      valid_gate_f = 1'b0;
      valid_gate_d = 1'b0;
      valid_gate_m = 1'b0;
      ForwardA_e   = FWD_RF;
      ForwardB_e   = FWD_RF;
      dmiss_busy   = 1'b0;
    end else if (freeze) begin
      // W drains (M/W loads a bubble) while everything up to M holds.
      en_f         = 1'b0;
      en_fd        = 1'b0;
      en_de        = 1'b0;
      en_em        = 1'b0;
      valid_gate_m = 1'b0;
    end else if (redirect_e) begin
      flush_n_fd = 1'b0;
      flush_n_de = 1'b0;
    end else if (load_use) begin
      // D/E keeps its payload but takes an invalid bubble; the load moves on,
      // so the condition clears by itself next cycle.
      en_f         = 1'b0;
      en_fd        = 1'b0;
      valid_gate_d = 1'b0;
    end else if (icache_miss) begin
      en_f         = 1'b0;
      valid_gate_f = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (!en_fd && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int VW = 15;

  localparam logic [VW-1:0] C_NORM  = {5'b11111, 2'b11, 3'b111, 2'b00, 2'b00, 1'b0};
  localparam logic [VW-1:0] C_RST   = {5'b11111, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0};
  localparam logic [VW-1:0] C_LU    = {5'b00111, 2'b11, 3'b101, 2'b00, 2'b00, 1'b0};
  localparam logic [VW-1:0] C_RDR   = {5'b11111, 2'b00, 3'b111, 2'b00, 2'b00, 1'b0};
  localparam logic [VW-1:0] C_IC    = {5'b01111, 2'b11, 3'b011, 2'b00, 2'b00, 1'b0};
  localparam logic [VW-1:0] C_ENTRY = {5'b00001, 2'b11, 3'b110, 2'b00, 2'b00, 1'b0};
  localparam logic [VW-1:0] C_MISS  = {5'b00001, 2'b11, 3'b110, 2'b00, 2'b00, 1'b1};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] Rs1_d, Rs2_d, Rs1_e, Rs2_e, Rd_e, Rd_m, Rd_w;
  logic          use_rs1_d, use_rs2_d;
  logic          RegWrite_e, RegWrite_m, RegWrite_w;
  logic          valid_e, valid_m, valid_w;
  logic [1:0]    ResultSrc_e;
  logic          redirect_e, dcache_miss, dcache_ready, icache_miss;
  logic          en_f, en_fd, en_de, en_em, en_mw;
  logic          flush_n_fd, flush_n_de;
  logic          valid_gate_f, valid_gate_d, valid_gate_m;
  logic [1:0]    ForwardA_e, ForwardB_e;
  logic [CW-1:0] stall_count;
  logic          dmiss_busy;

  hazard_ctrl #(.REG_ADDR_WIDTH(AW), .STALL_CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Rs1_d        (Rs1_d),
    .Rs2_d        (Rs2_d),
    .use_rs1_d    (use_rs1_d),
    .use_rs2_d    (use_rs2_d),
    .Rs1_e        (Rs1_e),
    .Rs2_e        (Rs2_e),
    .Rd_e         (Rd_e),
    .Rd_m         (Rd_m),
    .Rd_w         (Rd_w),
    .RegWrite_e   (RegWrite_e),
    .RegWrite_m   (RegWrite_m),
    .RegWrite_w   (RegWrite_w),
    .valid_e      (valid_e),
    .valid_m      (valid_m),
    .valid_w      (valid_w),
    .ResultSrc_e  (ResultSrc_e),
    .redirect_e   (redirect_e),
    .dcache_miss  (dcache_miss),
    .dcache_ready (dcache_ready),
    .icache_miss  (icache_miss),
    .en_f         (en_f),
    .en_fd        (en_fd),
    .en_de        (en_de),
    .en_em        (en_em),
    .en_mw        (en_mw),
    .flush_n_fd   (flush_n_fd),
    .flush_n_de   (flush_n_de),
    .valid_gate_f (valid_gate_f),
    .valid_gate_d (valid_gate_d),
    .valid_gate_m (valid_gate_m),
    .ForwardA_e   (ForwardA_e),
    .ForwardB_e   (ForwardB_e),
    .stall_count  (stall_count),
    .dmiss_busy   (dmiss_busy)
  );

  // scoreboard
  logic [VW+CW-1:0] exp_q[$];
  logic [CW-1:0]    exp_cnt;
  int               checks;
  int               errors;

  function automatic logic [VW-1:0] fwd_ctl(input logic [1:0] fa, input logic [1:0] fb);
    return {5'b11111, 2'b11, 3'b111, fa, fb, 1'b0};
  endfunction

  task automatic idle();
    Rs1_d = '0; Rs2_d = '0; Rs1_e = '0; Rs2_e = '0;
    Rd_e = '0; Rd_m = '0; Rd_w = '0;
    use_rs1_d = 1'b0; use_rs2_d = 1'b0;
    RegWrite_e = 1'b0; RegWrite_m = 1'b0; RegWrite_w = 1'b0;
    valid_e = 1'b0; valid_m = 1'b0; valid_w = 1'b0;
    ResultSrc_e = 2'b00;
    redirect_e = 1'b0; dcache_miss = 1'b0; dcache_ready = 1'b0; icache_miss = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven: queue the expectation,
  // compare mid-low-phase, advance the counter model, move to the next falling edge.
  task automatic step(input string tag, input logic [VW-1:0] e_ctl);
    logic [VW+CW-1:0] e;
    logic [VW-1:0]    got;
    exp_q.push_back({e_ctl, exp_cnt});
    #1;
    got = {en_f, en_fd, en_de, en_em, en_mw, flush_n_fd, flush_n_de,
           valid_gate_f, valid_gate_d, valid_gate_m, ForwardA_e, ForwardB_e, dmiss_busy};
    e = exp_q.pop_front();
    checks++;
    assert (got === e[VW+CW-1:CW]) else begin
      errors++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, got, e[VW+CW-1:CW]);
    end
    checks++;
    assert (stall_count === e[CW-1:0]) else begin
      errors++;
      $error("FAIL %s stall_count: observed %0d expected %0d", tag, stall_count, e[CW-1:0]);
    end
    if (!rst_n) exp_cnt = '0;
    else if (!e_ctl[13] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = '0;
    idle();
    rst_n = 1'b0;
    // Producers that would forward, to show reset masks the selects.
    Rs1_e = 5'd7; Rd_m = 5'd7; RegWrite_m = 1'b1; valid_m = 1'b1;
    repeat (2) @(negedge clk);
    step("reset", C_RST);

    rst_n = 1'b1; idle();
    step("normal", C_NORM);

    // load-use on rs1
    ResultSrc_e = 2'b01; valid_e = 1'b1; RegWrite_e = 1'b1; Rd_e = 5'd5;
    Rs1_d = 5'd5; use_rs1_d = 1'b1;
    step("loaduse_rs1", C_LU);
    valid_e = 1'b0;  // bubble now sits in E
    step("loaduse_done", C_NORM);

    // no stall when the decode instruction does not read the register
    valid_e = 1'b1; use_rs1_d = 1'b0;
    step("loaduse_unused", C_NORM);
    // x0 never stalls
    Rd_e = 5'd0; Rs1_d = 5'd0; use_rs1_d = 1'b1;
    step("loaduse_x0", C_NORM);
    // load-use on rs2
    Rd_e = 5'd9; Rs1_d = 5'd1; Rs2_d = 5'd9; use_rs2_d = 1'b1;
    step("loaduse_rs2", C_LU);
    idle();
    step("after_rs2", C_NORM);

    // redirect
    redirect_e = 1'b1;
    step("redirect", C_RDR);
    redirect_e = 1'b0;
    step("after_redirect", C_NORM);

    // redirect beats load-use
    redirect_e = 1'b1; ResultSrc_e = 2'b01; valid_e = 1'b1; RegWrite_e = 1'b1;
    Rd_e = 5'd3; Rs1_d = 5'd3; use_rs1_d = 1'b1;
    step("redirect_over_lu", C_RDR);
    idle();

    // icache miss, and load-use beating it
    icache_miss = 1'b1;
    step("icache_miss", C_IC);
    ResultSrc_e = 2'b01; valid_e = 1'b1; RegWrite_e = 1'b1;
    Rd_e = 5'd4; Rs2_d = 5'd4; use_rs2_d = 1'b1;
    step("lu_over_icache", C_LU);
    idle();
    step("after_icache", C_NORM);

    // forwarding
    Rs1_e = 5'd7; Rd_m = 5'd7; Rd_w = 5'd7;
    RegWrite_m = 1'b1; RegWrite_w = 1'b1; valid_m = 1'b1; valid_w = 1'b1;
    step("fwd_a_mem_wins", fwd_ctl(2'b10, 2'b00));
    Rd_m = 5'd0;
    step("fwd_a_wb", fwd_ctl(2'b01, 2'b00));
    Rs2_e = 5'd7;
    step("fwd_ab_wb", fwd_ctl(2'b01, 2'b01));
    Rd_m = 5'd7; Rs1_e = 5'd2;
    step("fwd_b_mem", fwd_ctl(2'b00, 2'b10));
    valid_m = 1'b0; valid_w = 1'b0;
    step("fwd_invalid", C_NORM);
    RegWrite_w = 1'b0; valid_w = 1'b1; Rs2_e = 5'd7;
    step("fwd_no_write", C_NORM);
    idle();

    // ready in RUN and miss without valid_m are ignored
    dcache_ready = 1'b1;
    step("ready_in_run", C_NORM);
    dcache_ready = 1'b0; dcache_miss = 1'b1;
    step("miss_not_valid", C_NORM);

    // D-miss together with redirect; ready coincident with entry is ignored
    valid_m = 1'b1; redirect_e = 1'b1; dcache_ready = 1'b1;
    step("miss_entry", C_ENTRY);
    dcache_ready = 1'b0; dcache_miss = 1'b0;  // miss drops without ready
    step("miss_wait1", C_MISS);
    step("miss_wait2", C_MISS);
    dcache_ready = 1'b1;
    step("miss_ready", C_MISS);
    dcache_ready = 1'b0; valid_m = 1'b0;
    step("redirect_after_miss", C_RDR);
    redirect_e = 1'b0;
    step("after_miss", C_NORM);

    // long miss to saturate the counter, then reset in the middle of it
    dcache_miss = 1'b1; valid_m = 1'b1;
    step("sat_entry", C_ENTRY);
    for (int i = 0; i < 12; i++) step("sat_wait", C_MISS);
    rst_n = 1'b0;
    step("reset_in_miss", C_RST);
    step("reset_held", C_RST);
    rst_n = 1'b1; idle();
    step("run_after_reset", C_NORM);
    step("run_after_reset2", C_NORM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit for the pipelined-plus-cache core. It is the driving end of every stage register's enable, flush and valid inputs, and it resolves four hazards:
- load-use, by stalling and inserting a bubble;
- taken branch/jump redirect, by flushing;
- data-cache miss, by freezing the pipeline through a small FSM;
- instruction-cache miss, by injecting fetch bubbles.

It also produces execute-stage forwarding selects and a saturating stall-cycle counter.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register index width
- STALL_CNT_WIDTH, 16, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- Rs1_d, Rs2_d  in  REG_ADDR_WIDTH  decode source registers
- use_rs1_d, use_rs2_d  in  1  decode instruction actually reads Rs1/Rs2
- Rs1_e, Rs2_e  in  REG_ADDR_WIDTH  execute source registers
- Rd_e, Rd_m, Rd_w  in  REG_ADDR_WIDTH  destination registers per stage
- RegWrite_e, RegWrite_m, RegWrite_w  in  1  write enables per stage
- valid_e, valid_m, valid_w  in  1  stage valid bits
- ResultSrc_e  in  2  execute result source; 2'b01 = load
- redirect_e  in  1  taken branch or jump resolved in execute
- dcache_miss  in  1  level; memory-stage access missed
- dcache_ready  in  1  pulse; refill complete
- icache_miss  in  1  level; fetch missed
- en_f, en_fd, en_de, en_em, en_mw  out  1  stall enables (0 = hold) for PC and each stage register
- flush_n_fd, flush_n_de  out  1  active-low synchronous clear to the F/D and D/E registers
- valid_gate_f, valid_gate_d, valid_gate_m  out  1  valid fed into F/D, D/E and M/W respectively
- ForwardA_e, ForwardB_e  out  2  00 register file, 01 writeback, 10 memory
- stall_count  out  STALL_CNT_WIDTH  cycles with en_fd=0, saturating
- dmiss_busy  out  1  FSM in MISS

## Operation
- FSM states: RUN, MISS (hazard_pkg enum).
  - RUN→MISS when dcache_miss && valid_m.
  - MISS→RUN on the cycle after dcache_ready is sampled high.
  - dcache_ready in RUN is ignored.
- Priority per cycle (highest first): MISS (or the RUN→MISS entry cycle), then redirect_e, then load-use, then icache_miss, then normal.
- MISS / entry cycle:
  - en_f, en_fd, en_de, en_em = 0.
  - en_mw = 1 with valid_gate_m = 0, so W drains and M is held.
  - Both flushes inactive.
- Redirect (RUN): all enables 1, flush_n_fd = 0, flush_n_de = 0. The branch itself advances to M. A redirect asserted while in MISS stays held by the frozen E register and is acted on in the first RUN cycle; no separate pending register is needed.
- Load-use: ResultSrc_e==01 && valid_e && RegWrite_e && Rd_e!=0 && ((use_rs1_d && Rd_e==Rs1_d) || (use_rs2_d && Rd_e==Rs2_d)).
  - Response: en_f = en_fd = 0, en_de = 1 with valid_gate_d = 0.
  - The D/E register holds its payload and clears its valid.
  - Lasts exactly one cycle.
- icache_miss (RUN, no higher event): en_f = 0, en_fd = 1, valid_gate_f = 0.
- Normal: all enables 1, flushes 1, all valid gates 1.
- Forwarding (combinational, independent of FSM):
  - ForwardA = 10 if valid_m && RegWrite_m && Rd_m!=0 && Rd_m==Rs1_e;
  - else 01 for the same condition on W;
  - else 00.
  - ForwardB is identical using Rs2_e.
  - When both M and W match, M wins.
- stall_count increments on every cycle with en_fd=0 and saturates at all-ones.

## Timing
- All control outputs are combinational from the current state and inputs, with zero latency into the stage registers' next edge.
- Registered state: FSM state, stall_count.
- During rst_n=0, outputs are forced to:
  - en_* = 1, flush_n_* = 0, valid_gate_* = 0;
  - Forward* = 00, dmiss_busy = 0.
- At the first edge in reset, state becomes RUN and stall_count becomes 0.
- Reset during MISS returns the FSM to RUN immediately; no refill handshake is completed.
- dcache_ready coincident with a new dcache_miss in RUN: enter MISS (ready ignored).
- dcache_miss deasserting without dcache_ready does not exit MISS.
- A MISS of N wait cycles plus the ready cycle adds N+1 to stall_count.

## Structure
- hazard_pkg holds:
  - state enum {RUN, MISS};
  - RESULT_SRC_LOAD = 2'b01;
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- One sub-module, hazard_forward_unit: purely combinational forwarding select, instantiated once per operand.

## Test plan
- Load x5 in E with Rs1_d=5, use_rs1_d=1 -> exactly one cycle of en_fd=0, en_de=1, valid_gate_d=0; stall_count 0→1.
- redirect_e=1 in RUN -> flush_n_fd=flush_n_de=0, all enables 1, for one cycle.
- dcache_miss with valid_m, ready after 3 cycles -> 4 frozen cycles with en_mw=1 and valid_gate_m=0; RUN on the 5th cycle; stall_count += 4.
- redirect_e and dcache_miss together -> MISS handling first; flush occurs in the first RUN cycle.
- Rd_m=Rd_w=7=Rs1_e, both writing -> ForwardA=10; Rd_m=0 with Rd_w=7 -> ForwardA=01.
- rst_n low mid-MISS -> next cycle state RUN, stall_count=0, outputs at their reset values.
